rx_fsm: RTL and testbench
=========================

RX_FSM -- requirements
Module: rx_fsm

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port rx_in, input, 1, serial line, already synchronised, idle high.
REQ-004 SHALL have port par_en, input, 1, parity bit present in frame when 1.
REQ-005 SHALL have port prescale, input, 6, oversampling ratio; legal values are 8, 16 and 32.
REQ-006 SHALL have port strt_glitch, input, 1, start-check result; 1 means false start.
REQ-007 SHALL have ports par_err and stp_err, input, 1 each, registered checker results.
REQ-008 SHALL have port edge_cnt, output, 6, oversample index within the current bit.
REQ-009 SHALL have port bit_cnt, output, 4, data bit index 0..7.
REQ-010 SHALL have ports dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en and deser_en, output, 1 each, datapath enables.
REQ-011 SHALL have port data_valid, output, 1, one-cycle frame-good pulse.

Function
REQ-012 SHALL implement states IDLE, START, DATA, PARITY and STOP.
REQ-013 IDLE: rx_in==0 SHALL cause transition to START with edge_cnt=0; otherwise SHALL remain in IDLE.
REQ-014 Any prescale value other than 8, 16 or 32 SHALL be treated as 8; P denotes the effective ratio.
REQ-015 In non-IDLE states, edge_cnt SHALL increment each cycle and wrap from P-1 to 0; in IDLE it SHALL hold 0.
REQ-016 dat_samp_en SHALL be 1 in every non-IDLE state and 0 in IDLE.
REQ-017 START: strt_chk_en SHALL be 1 for exactly the cycle edge_cnt==P-2.
REQ-018 START, at edge_cnt==P-1: if strt_glitch==1, SHALL go to IDLE; otherwise SHALL go to DATA with bit_cnt=0.
REQ-019 DATA: deser_en SHALL be 1 for exactly the cycle edge_cnt==P-2.
REQ-020 DATA, at edge_cnt==P-1: bit_cnt SHALL increment; after bit 7, SHALL go to PARITY if par_en==1, else to STOP, with bit_cnt=0.
REQ-021 PARITY: par_chk_en SHALL be 1 at edge_cnt==P-2; at edge_cnt==P-1 SHALL go to STOP.
REQ-022 STOP: stp_chk_en SHALL be 1 at edge_cnt==P-2.
REQ-023 STOP, at edge_cnt==P-1: SHALL go to IDLE, and SHALL pulse data_valid for that single cycle iff stp_err==0 and (par_en==0 or par_err==0).
REQ-024 par_en and prescale SHALL be sampled on the IDLE->START transition and held constant for the frame.
REQ-025 rx_in SHALL be ignored in every non-IDLE state.
REQ-026 The earliest next frame start SHALL be detected on the cycle after STOP exits.
REQ-027 All outputs SHALL be registered; every enable SHALL be a pulse of at most one cycle per bit.

Reset
REQ-028 rst low SHALL immediately force state IDLE, clear edge_cnt and bit_cnt to 0, and clear all enables and data_valid to 0, including mid-frame.
REQ-029 After rst release, the first frame SHALL require a fresh falling rx_in.

Configuration
REQ-030 Macro RX_FSM_ERR_CNT_EN SHALL, when defined, add output err_cnt (8 bits, reset 0), which increments on each glitch abort or failed stop and saturates at 255.
REQ-031 Without RX_FSM_ERR_CNT_EN, port err_cnt and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 prescale=8, par_en=0, frame 0x55, no errors -> 8 deser_en pulses, then data_valid at cycle 80 after start detect.
REQ-033 prescale=16, par_en=1, par_err=1 at STOP -> no data_valid, return to IDLE; err_cnt=1 when the macro is enabled.
REQ-034 strt_glitch=1 at START edge_cnt==15 -> IDLE, no deser_en, no data_valid.
REQ-035 prescale=5 -> behaviour identical to prescale=8; the STOP exit is at edge_cnt==7.
REQ-036 rst asserted in DATA at bit_cnt=4 -> all outputs 0 in the same cycle, IDLE after release.
REQ-037 Two back-to-back frames at prescale=32 -> two data_valid pulses, the second START entered one cycle after the first STOP exit.

Source files
------------

// File: rtl/rx_fsm.sv
// rx_fsm: UART receive control FSM (IDLE/START/DATA/PARITY/STOP).
// Generates the oversample/bit counters and the one-cycle datapath enables
// for an oversampled serial receiver, and a data_valid pulse per good frame.
// Optional macro RX_FSM_ERR_CNT_EN adds an 8-bit saturating error counter
// output (err_cnt) counting glitch aborts and failed frames.
module rx_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       par_en,
    input  logic [5:0] prescale,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       deser_en,
    output logic       data_valid
`ifdef RX_FSM_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t     state, state_n;
    logic [5:0] edge_n;
    logic [3:0] bit_n;
    logic [5:0] p_q, p_n, p_sel;
    logic       par_en_q, par_en_n;
    logic       armed;
    logic       last;
    logic       on_chk;
    logic       valid_n;
    logic       samp_n, strt_n, par_chk_n, stp_n, deser_n;

    // Map the requested oversampling ratio onto a legal value (default 8).
    always_comb begin
        p_sel = 6'd8;
        if (prescale == 6'd16) begin
            p_sel = 6'd16;
        end else if (prescale == 6'd32) begin
            p_sel = 6'd32;
        end
    end

    // Next-state, counter and registered-output-next computation.
    always_comb begin
        state_n  = state;
        edge_n   = edge_cnt;
        bit_n    = bit_cnt;
        p_n      = p_q;
        par_en_n = par_en_q;
        valid_n  = 1'b0;
        last     = (edge_cnt == (p_q - 6'd1));

        if (state != IDLE) begin
            edge_n = last ? '0 : edge_cnt + 6'd1;
        end

        case (state)
            IDLE: begin
                edge_n = '0;
                bit_n  = '0;
                // Frame configuration is latched here and held for the frame.
                if (armed && !rx_in) begin
                    state_n  = START;
                    p_n      = p_sel;
                    par_en_n = par_en;
                end
            end
            START: begin
                if (last) begin
                    if (strt_glitch) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        bit_n   = '0;
                    end
                end
            end
            DATA: begin
                if (last) begin
                    if (bit_cnt == 4'd7) begin
                        bit_n   = '0;
                        state_n = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_n = bit_cnt + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (last) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                if (last) begin
                    state_n = IDLE;
                    valid_n = !stp_err && (!par_en_q || !par_err);
                end
            end
            default: begin
                state_n = IDLE;
                edge_n  = '0;
                bit_n   = '0;
            end
        endcase

        // Enables are computed against the next-cycle counters so that the
        // registered enable lines up with the registered edge_cnt value.
        on_chk    = (edge_n == (p_n - 6'd2));
        samp_n    = (state_n != IDLE);
        strt_n    = (state_n == START)  && on_chk;
        deser_n   = (state_n == DATA)   && on_chk;
        par_chk_n = (state_n == PARITY) && on_chk;
        stp_n     = (state_n == STOP)   && on_chk;
    end

    // FSM state, counters and latched frame configuration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            p_q      <= 6'd8;
            par_en_q <= 1'b0;
        end else begin
            state    <= state_n;
            edge_cnt <= edge_n;
            bit_cnt  <= bit_n;
            p_q      <= p_n;
            par_en_q <= par_en_n;
        end
    end

    // Arm start detection only after the line has been seen idle-high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed <= 1'b0;
        end else if (state == IDLE && rx_in) begin
            armed <= 1'b1;
        end
    end

    // Registered datapath enables and frame-good pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dat_samp_en <= 1'b0;
            strt_chk_en <= 1'b0;
            par_chk_en  <= 1'b0;
            stp_chk_en  <= 1'b0;
            deser_en    <= 1'b0;
            data_valid  <= 1'b0;
        end else begin
            dat_samp_en <= samp_n;
            strt_chk_en <= strt_n;
            par_chk_en  <= par_chk_n;
            stp_chk_en  <= stp_n;
            deser_en    <= deser_n;
            data_valid  <= valid_n;
        end
    end

`ifdef RX_FSM_ERR_CNT_EN
    logic err_inc;

    // Error event: false start abort, or a STOP exit without data_valid.
    always_comb begin
        err_inc = 1'b0;
        if (last && state == START && strt_glitch) begin
            err_inc = 1'b1;
        end
        if (last && state == STOP && !valid_n) begin
            err_inc = 1'b1;
        end
    end

    // Saturating error counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (err_inc && err_cnt != 8'd255) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rx_fsm.sv
// tb_rx_fsm: scoreboard bench for rx_fsm. Expected per-frame results are
// queued when a frame is driven and compared when the frame ends.
module tb_rx_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_in = 1'b0;
    logic       par_en = 1'b0;
    logic [5:0] prescale = 6'd8;
    logic       strt_glitch = 1'b0;
    logic       par_err = 1'b0;
    logic       stp_err = 1'b0;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid;
`ifdef RX_FSM_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    always #5 clk = ~clk;

    rx_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .par_en      (par_en),
        .prescale    (prescale),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .dat_samp_en (dat_samp_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .deser_en    (deser_en),
        .data_valid  (data_valid)
`ifdef RX_FSM_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    typedef struct {
        int len;
        int deser;
        int par;
        int stp;
        int max_edge;
        int valid;
        int gap;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    int   exp_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int eff_p(input logic [5:0] ps);
        if (ps == 6'd16) return 16;
        if (ps == 6'd32) return 32;
        return 8;
    endfunction

    // Drive one frame starting from a negedge in IDLE; returns at the negedge
    // of the first IDLE cycle after the frame.
    task automatic send_frame(input logic [5:0] ps, input bit pe, input bit glitch,
                              input bit perr, input bit serr, input int gap);
        exp_t e;
        int   p;
        p          = eff_p(ps);
        e.len      = glitch ? p : p * (pe ? 11 : 10);
        e.deser    = glitch ? 0 : 8;
        e.par      = (pe && !glitch) ? 1 : 0;
        e.stp      = glitch ? 0 : 1;
        e.max_edge = p - 1;
        e.valid    = (!glitch && !serr && (!pe || !perr)) ? 1 : 0;
        e.gap      = gap;
        sb.push_back(e);
        prescale    = ps;
        par_en      = pe;
        strt_glitch = glitch;
        par_err     = perr;
        stp_err     = serr;
        rx_in       = 1'b0;
        @(negedge clk);
        // Mid-frame: line noise and configuration changes must be ignored.
        rx_in    = 1'($urandom_range(0, 1));
        prescale = 6'($urandom_range(0, 63));
        par_en   = !pe;
        repeat (e.len) begin
            @(negedge clk);
            rx_in = 1'($urandom_range(0, 1));
        end
        rx_in    = 1'b1;
        prescale = ps;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: accumulate per-frame observations, compare at frame end.
    int   m_len, m_deser, m_strt, m_par, m_stp, m_maxe, m_vin, m_gap, idle_len;
    bit   active = 1'b0;
    exp_t m_e;
    always @(negedge clk) begin
        if (!mon_en) begin
            active   = 1'b0;
            idle_len = 0;
        end else if (dat_samp_en) begin
            if (!active) begin
                active  = 1'b1;
                m_len   = 0;
                m_deser = 0;
                m_strt  = 0;
                m_par   = 0;
                m_stp   = 0;
                m_maxe  = 0;
                m_vin   = 0;
                m_gap   = idle_len;
                check("start_edge0", 32'(edge_cnt), 0);
            end
            m_len++;
            m_deser += int'(deser_en);
            m_strt  += int'(strt_chk_en);
            m_par   += int'(par_chk_en);
            m_stp   += int'(stp_chk_en);
            m_vin   += int'(data_valid);
            if (int'(edge_cnt) > m_maxe) m_maxe = int'(edge_cnt);
        end else begin
            if (active) begin
                active = 1'b0;
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    m_e = sb.pop_front();
                    check("frame_len", m_len, m_e.len);
                    check("deser_pulses", m_deser, m_e.deser);
                    check("strt_pulses", m_strt, 1);
                    check("par_pulses", m_par, m_e.par);
                    check("stp_pulses", m_stp, m_e.stp);
                    check("max_edge", m_maxe, m_e.max_edge);
                    check("valid_in_frame", m_vin, 0);
                    check("data_valid", 32'(data_valid), m_e.valid);
                    if (m_e.gap >= 0) check("idle_gap", m_gap, m_e.gap);
                    if (m_e.valid == 0 && exp_err < 255) exp_err++;
`ifdef RX_FSM_ERR_CNT_EN
                    check("err_cnt", 32'(err_cnt), exp_err);
`endif
                end
                idle_len = 1;
            end else begin
                check("idle_valid", 32'(data_valid), 0);
                idle_len++;
            end
        end
    end

    initial begin
        // Reset with the line held low: outputs clear, no start afterwards.
        rst   = 1'b0;
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({edge_cnt, bit_cnt, dat_samp_en, strt_chk_en,
                                    par_chk_en, stp_chk_en, deser_en, data_valid}), 0);
`ifdef RX_FSM_ERR_CNT_EN
        check("reset_err_cnt", 32'(err_cnt), 0);
`endif
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("held_low_no_start", 32'(dat_samp_en), 0);
        idle(2);
        mon_en = 1'b1;

        send_frame(6'd8, 1'b0, 1'b0, 1'b0, 1'b0, -1);   // 0x55-style clean frame, P=8
        idle(3);
        send_frame(6'd16, 1'b1, 1'b0, 1'b1, 1'b0, -1);  // parity error
        idle(2);
        send_frame(6'd16, 1'b0, 1'b1, 1'b0, 1'b0, -1);  // false start
        idle(2);
        send_frame(6'd5, 1'b1, 1'b0, 1'b0, 1'b0, -1);   // illegal prescale acts as 8
        idle(2);
        send_frame(6'd8, 1'b1, 1'b0, 1'b0, 1'b1, -1);   // stop error
        idle(2);
        send_frame(6'd32, 1'b0, 1'b0, 1'b0, 1'b0, -1);  // back-to-back pair
        send_frame(6'd32, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        idle(3);

        // Asynchronous reset in DATA at bit 4.
        mon_en      = 1'b0;
        prescale    = 6'd8;
        par_en      = 1'b0;
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        rx_in       = 1'b0;
        @(negedge clk);
        rx_in = 1'b1;
        repeat (43) @(negedge clk);
        check("pre_reset_bit_cnt", 32'(bit_cnt), 4);
        rst = 1'b0;
        #1;
        check("midframe_reset_outputs", 32'({edge_cnt, bit_cnt, dat_samp_en, strt_chk_en,
                                             par_chk_en, stp_chk_en, deser_en, data_valid}), 0);
`ifdef RX_FSM_ERR_CNT_EN
        check("midframe_reset_err_cnt", 32'(err_cnt), 0);
`endif
        exp_err = 0;
        rx_in   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_no_start", 32'(dat_samp_en), 0);
        idle(2);
        mon_en = 1'b1;
        send_frame(6'd16, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(2);

`ifdef RX_FSM_ERR_CNT_EN
        // Drive enough false starts to saturate the error counter.
        for (int i = 0; i < 260; i++) begin
            send_frame(6'd8, 1'b0, 1'b1, 1'b0, 1'b0, -1);
            idle(1);
        end
`endif

        idle(3);
        check("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
